// File: rtl/deser_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | deser_pkg: shared state encoding and mode constants for the         |
// | frame deserialiser controller.            Rev 1.0                   |
// +----------------------------------------------------------------------+
package deser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SKIP  = 2'd1,
    SHIFT = 2'd2,
    FULL  = 2'd3
  } state_t;

  localparam logic MODE_ALL  = 1'b0;
  localparam logic MODE_SKIP = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mod_counter: up-counter with sync clear (priority), enable and      |
// | async active-high reset; wraps naturally at 2^W.   Rev 1.0          |
// +----------------------------------------------------------------------+
module mod_counter #(
  parameter int W = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/deser_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | deser_frame_ctrl: frames a serial bit stream into WORD_BITS words,  |
// | with optional prefix skip and word handshake.      Rev 1.0          |
// +----------------------------------------------------------------------+
module deser_frame_ctrl #(
  parameter int CW        = 4,
  parameter int WORD_BITS = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          En,
  input  logic          Start,
  input  logic          Mode,
  input  logic [CW-1:0] Skip,
  input  logic [CW-1:0] Len,
  input  logic          word_ack,
  output logic          shifterEn,
  output logic          word_ready,
  output logic          busy,
  output logic          overrun,
  output logic [CW-1:0] word_cnt
);

  import deser_pkg::*;

  localparam int            BW       = (WORD_BITS > 2) ? $clog2(WORD_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_BITS - 1);

  state_t        r_state;
  state_t        w_state_n;
  logic [CW-1:0] r_skip;
  logic [CW-1:0] r_len;
  logic          r_word_ready;
  logic          r_overrun;

  logic [CW-1:0] w_skip_cnt;
  logic [BW-1:0] w_bit_cnt;
  logic          w_latch;
  logic          w_skip_clr, w_skip_inc;
  logic          w_bit_clr,  w_bit_inc;
  logic          w_word_clr, w_word_inc;
  logic          w_ovr_set;
  logic          w_shift;

  mod_counter #(.W(CW)) u_skip_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (w_skip_clr),
    .en    (w_skip_inc),
    .q     (w_skip_cnt)
  );

  mod_counter #(.W(BW)) u_bit_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (w_bit_clr),
    .en    (w_bit_inc),
    .q     (w_bit_cnt)
  );

  mod_counter #(.W(CW)) u_word_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (w_word_clr),
    .en    (w_word_inc),
    .q     (word_cnt)
  );

  always_comb begin
    w_state_n  = r_state;
    w_latch    = 1'b0;
    w_skip_clr = 1'b0;
    w_skip_inc = 1'b0;
    w_bit_clr  = 1'b0;
    w_bit_inc  = 1'b0;
    w_word_clr = 1'b0;
    w_word_inc = 1'b0;
    w_ovr_set  = 1'b0;
    w_shift    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (Start) begin
          w_latch    = 1'b1;
          w_skip_clr = 1'b1;
          w_bit_clr  = 1'b1;
          w_word_clr = 1'b1;
          w_state_n  = (Mode == MODE_SKIP && Skip != '0) ? SKIP : SHIFT;
        end
      end
      SKIP: begin
        if (En) begin
          if (w_skip_cnt == (r_skip - CW'(1))) begin
            w_skip_clr = 1'b1;
            w_state_n  = SHIFT;
          end else begin
            w_skip_inc = 1'b1;
          end
        end
      end
      SHIFT: begin
        w_shift = En;
        if (En) begin
          if (w_bit_cnt == LAST_BIT) begin
            w_bit_clr  = 1'b1;
            w_word_inc = 1'b1;
            w_state_n  = FULL;
          end else begin
            w_bit_inc = 1'b1;
          end
        end
      end
      FULL: begin
        w_ovr_set = En;
        // Len of zero wraps with word_cnt, so a full 2^CW-word frame also matches here
        if (word_ack) begin
          w_state_n = (word_cnt == r_len) ? IDLE : SHIFT;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_skip       <= '0;
      r_len        <= '0;
      r_word_ready <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_word_ready <= (w_state_n == FULL);
      if (w_latch) begin
        r_skip    <= Skip;
        r_len     <= Len;
        r_overrun <= 1'b0;
      end else if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign shifterEn  = w_shift;
  assign word_ready = r_word_ready;
  assign busy       = (r_state != IDLE);
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_deser_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_deser_frame_ctrl: two instances (8-bit and 3-bit words) driven   |
// | by shared stimulus, each compared to a frame-level model. Rev 1.0   |
// +----------------------------------------------------------------------+
module tb_deser_frame_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          Reset, En, Start, Mode, word_ack;
  logic [CW-1:0] Skip, Len;

  logic          se [2];
  logic          wr [2];
  logic          bz [2];
  logic          ov [2];
  logic [CW-1:0] wc [2];

  int errors = 0;
  int checks = 0;

  // Frame-level model: remaining skip bits, bits in current word, words done.
  bit m_act  [2];
  bit m_hold [2];
  bit m_ovr  [2];
  int m_skip [2];
  int m_bits [2];
  int m_words[2];
  int m_len  [2];
  int wb     [2] = '{8, 3};

  always #5 clk = ~clk;

  deser_frame_ctrl #(.CW(CW), .WORD_BITS(8)) u_w8 (
    .Clk(clk), .Reset(Reset), .En(En), .Start(Start), .Mode(Mode),
    .Skip(Skip), .Len(Len), .word_ack(word_ack),
    .shifterEn(se[0]), .word_ready(wr[0]), .busy(bz[0]),
    .overrun(ov[0]), .word_cnt(wc[0])
  );

  deser_frame_ctrl #(.CW(CW), .WORD_BITS(3)) u_w3 (
    .Clk(clk), .Reset(Reset), .En(En), .Start(Start), .Mode(Mode),
    .Skip(Skip), .Len(Len), .word_ack(word_ack),
    .shifterEn(se[1]), .word_ready(wr[1]), .busy(bz[1]),
    .overrun(ov[1]), .word_cnt(wc[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_hold[i] = 0; m_ovr[i] = 0;
      m_skip[i] = 0; m_bits[i] = 0; m_words[i] = 0; m_len[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!m_act[i]) begin
        if (Start) begin
          m_act[i]   = 1;
          m_skip[i]  = Mode ? int'(Skip) : 0;
          m_bits[i]  = 0;
          m_words[i] = 0;
          m_ovr[i]   = 0;
          m_len[i]   = (Len == 0) ? (1 << CW) : int'(Len);
        end
      end else if (m_hold[i]) begin
        if (En) m_ovr[i] = 1;
        if (word_ack) begin
          m_hold[i] = 0;
          if (m_words[i] == m_len[i]) m_act[i] = 0;
        end
      end else if (m_skip[i] > 0) begin
        if (En) m_skip[i]--;
      end else if (En) begin
        m_bits[i]++;
        if (m_bits[i] == wb[i]) begin
          m_bits[i] = 0;
          m_words[i]++;
          m_hold[i] = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d.shifterEn", i), 32'(se[i]),
            32'(m_act[i] && !m_hold[i] && m_skip[i] == 0 && En));
      check($sformatf("u%0d.word_ready", i), 32'(wr[i]), 32'(m_hold[i]));
      check($sformatf("u%0d.busy", i), 32'(bz[i]), 32'(m_act[i]));
      check($sformatf("u%0d.overrun", i), 32'(ov[i]), 32'(m_ovr[i]));
      check($sformatf("u%0d.word_cnt", i), 32'(wc[i]), 32'(m_words[i] % (1 << CW)));
    end
  endtask

  // Called at a negedge: drive, check, take the rising edge, return at the next negedge.
  task automatic step(input bit en, input bit st, input bit md, input int sk,
                      input int ln, input bit ak, input bit rs);
    Reset = rs; En = en; Start = st; Mode = md;
    Skip = CW'(sk); Len = CW'(ln); word_ack = ak;
    if (rs) model_reset();
    #1;
    check_all();
    @(posedge clk);
    if (!rs) model_edge();
    @(negedge clk);
  endtask

  initial begin
    Reset = 1'b1; En = 1'b0; Start = 1'b0; Mode = 1'b0;
    Skip = '0; Len = '0; word_ack = 1'b0;
    model_reset();
    @(negedge clk);
    step(1, 1, 0, 0, 1, 0, 1);
    step(1, 1, 0, 0, 1, 0, 1);

    // Mode 0, one word, start accepted on first edge after reset release
    step(0, 1, 0, 0, 1, 0, 0);
    for (int k = 0; k < 8; k++) step(1, 0, 1, 5, 3, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Skip 3, two words, ack held high throughout
    step(0, 1, 1, 3, 2, 1, 0);
    for (int k = 0; k < 26; k++) step(1, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);

    // Overrun: word held while En toggles, sticky until next Start
    step(0, 1, 0, 0, 2, 0, 0);
    for (int k = 0; k < 8; k++) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 8; k++) step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);

    // Reset in the middle of a word, then a clean frame
    for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 1, 2, 1, 0, 0);
    for (int k = 0; k < 12; k++) step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);

    // Len 0: 2^CW words, Start held high during the frame
    step(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 170; k++) step(1, 1, 1, 7, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Mode 1 with Skip 0 goes straight to shifting
    step(0, 1, 1, 0, 3, 0, 0);
    for (int k = 0; k < 30; k++) step(1, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);

    for (int k = 0; k < 4000; k++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 1'($urandom),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 599) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
